// File: rtl/btn_pkg.sv
// Shared types for the button event generator: FSM states, event codes and the
// per-cycle pulse bundle.
package btn_pkg;

  localparam int unsigned EVT_W = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    WAIT2    = 3'd2,
    PRESSED2 = 3'd3,
    LONG     = 3'd4
  } btn_state_t;

  typedef enum logic [EVT_W-1:0] {
    EVT_NONE    = 3'd0,
    EVT_PRESS   = 3'd1,
    EVT_RELEASE = 3'd2,
    EVT_CLICK   = 3'd3,
    EVT_DOUBLE  = 3'd4,
    EVT_LONG    = 3'd5,
    EVT_REPEAT  = 3'd6
  } evt_code_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dbl;
    logic lng;
    logic rpt;
  } pulses_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// Button event bus: debounced level in, event pulses and the one-entry
// valid/ready event register out.
interface button_event_gen_if;
  import btn_pkg::*;

  logic      db;
  logic      press_p;
  logic      release_p;
  logic      click_p;
  logic      dbl_p;
  logic      long_p;
  logic      repeat_p;
  logic      held;
  logic      evt_valid;
  evt_code_t evt_code;
  logic      evt_ready;
  logic      overrun;

  modport master (
    input  db, evt_ready,
    output press_p, release_p, click_p, dbl_p, long_p, repeat_p,
           held, evt_valid, evt_code, overrun
  );

  modport slave (
    output db, evt_ready,
    input  press_p, release_p, click_p, dbl_p, long_p, repeat_p,
           held, evt_valid, evt_code, overrun
  );
endinterface

// File: rtl/tick_gen.sv
// Timing-tick prescaler: one-cycle registered pulse every M clocks,
// synchronous active-low reset.
module tick_gen #(
  parameter int unsigned M = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/button_event_gen.sv
// Classifies the debounced button level into press/release/click/double/long/
// repeat pulses and queues one coded event behind a valid/ready register.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned TICK_M       = 100_000,
  parameter int unsigned LONG_TICKS   = 800,
  parameter int unsigned REPEAT_TICKS = 150,
  parameter int unsigned DOUBLE_TICKS = 250
) (
  input logic               clk,
  input logic               reset,
  button_event_gen_if.master bus
);
  localparam int unsigned CNT_W = $clog2(max3(LONG_TICKS, REPEAT_TICKS, DOUBLE_TICKS) + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_END  = CNT_W'(DOUBLE_TICKS - 1);

  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_clr;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_db_q;
  pulses_t          r_pulse;
  pulses_t          w_pulse;
  logic             r_held;
  logic             r_evt_valid;
  logic             w_evt_valid_nxt;
  evt_code_t        r_evt_code;
  evt_code_t        w_evt_code_nxt;
  evt_code_t        w_code;
  logic             r_overrun;
  logic             w_overrun_nxt;

  tick_gen #(.M(TICK_M)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  assign w_rise = bus.db & ~r_db_q;
  assign w_fall = ~bus.db & r_db_q;

  // Next state and pulses; db edges beat tick-driven timeouts in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = '0;
    w_cnt_clr   = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt   = PRESSED;
          w_pulse.press = 1'b1;
        end
      end
      PRESSED, PRESSED2: begin
        if (w_fall) begin
          if (r_state == PRESSED) w_state_nxt = WAIT2;
          else                    w_state_nxt = IDLE;
          w_pulse.rel = 1'b1;
        end else if (w_tick && (r_cnt == LONG_END)) begin
          w_state_nxt = LONG;
          w_pulse.lng = 1'b1;
        end
      end
      WAIT2: begin
        if (w_rise) begin
          w_state_nxt   = PRESSED2;
          w_pulse.press = 1'b1;
          w_pulse.dbl   = 1'b1;
        end else if (w_tick && (r_cnt == DBL_END)) begin
          w_state_nxt   = IDLE;
          w_pulse.click = 1'b1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_pulse.rel = 1'b1;
        end else if (w_tick && (r_cnt == REP_END)) begin
          w_pulse.rpt = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_cnt_clr || (w_state_nxt != r_state)) begin
      w_cnt_nxt = '0;
    end else if (w_tick && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Highest-priority pulse is offered to the event register; a full, stalled register drops it.
  always_comb begin
    w_code          = EVT_NONE;
    w_evt_valid_nxt = r_evt_valid;
    w_evt_code_nxt  = r_evt_code;
    w_overrun_nxt   = r_overrun;
    if      (w_pulse.dbl)   w_code = EVT_DOUBLE;
    else if (w_pulse.lng)   w_code = EVT_LONG;
    else if (w_pulse.rpt)   w_code = EVT_REPEAT;
    else if (w_pulse.click) w_code = EVT_CLICK;
    else if (w_pulse.rel)   w_code = EVT_RELEASE;
    else if (w_pulse.press) w_code = EVT_PRESS;
    if (w_code != EVT_NONE) begin
      if (!r_evt_valid || bus.evt_ready) begin
        w_evt_valid_nxt = 1'b1;
        w_evt_code_nxt  = w_code;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_evt_valid && bus.evt_ready) begin
      w_evt_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_db_q      <= 1'b0;
      r_pulse     <= '0;
      r_held      <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_code  <= EVT_NONE;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_db_q      <= bus.db;
      r_pulse     <= w_pulse;
      r_held      <= (w_state_nxt == PRESSED) || (w_state_nxt == PRESSED2) ||
                     (w_state_nxt == LONG);
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_code  <= w_evt_code_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.press_p   = r_pulse.press;
  assign bus.release_p = r_pulse.rel;
  assign bus.click_p   = r_pulse.click;
  assign bus.dbl_p     = r_pulse.dbl;
  assign bus.long_p    = r_pulse.lng;
  assign bus.repeat_p  = r_pulse.rpt;
  assign bus.held      = r_held;
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_code  = r_evt_code;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios plus random db/ready traffic,
// every cycle checked against a timestamp-based reference model.
module tb_button_event_gen;
  import btn_pkg::*;

  localparam int TM = 4;
  localparam int LT = 5;
  localparam int RT = 2;
  localparam int DT = 3;
  localparam int MIDLE = 0, MHOLD = 1, MGAP = 2, MHOLD2 = 3, MLONG = 4;

  logic clk = 1'b0;
  logic reset;

  button_event_gen_if bus();

  button_event_gen #(
    .TICK_M(TM), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .DOUBLE_TICKS(DT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: k = edges since reset, t0 = edge at which the current phase began.
  int          k;
  int          mode;
  int          t0;
  logic        m_prev_db;
  logic        e_held, e_valid, e_ovr;
  logic [2:0]  e_code;
  logic [11:0] exp_vec;
  logic [11:0] obs_vec;

  // Ticks reach the FSM at edges k where k-1 is a positive multiple of TM.
  function automatic int nticks(input int kk);
    return (kk < 1) ? 0 : (kk - 1) / TM;
  endfunction

  function automatic bit tick_at(input int kk);
    return (kk > 1) && (((kk - 1) % TM) == 0);
  endfunction

  task automatic model_edge();
    logic pr, rl, ck, dd, lg, rp, rise, fall, tk, d;
    int n;
    logic [2:0] code;
    {pr, rl, ck, dd, lg, rp} = 6'b0;
    if (!reset) begin
      k = 0; mode = MIDLE; t0 = 0; m_prev_db = 1'b0;
      e_held = 1'b0; e_valid = 1'b0; e_ovr = 1'b0; e_code = 3'd0;
    end else begin
      k++;
      d = bus.db;
      rise = d & ~m_prev_db;
      fall = ~d & m_prev_db;
      m_prev_db = d;
      tk = tick_at(k);
      n = nticks(k) - nticks(t0);
      case (mode)
        MIDLE: if (rise) begin mode = MHOLD; t0 = k; pr = 1'b1; end
        MHOLD, MHOLD2: begin
          if (fall) begin mode = (mode == MHOLD) ? MGAP : MIDLE; t0 = k; rl = 1'b1; end
          else if (tk && n == LT) begin mode = MLONG; t0 = k; lg = 1'b1; end
        end
        MGAP: begin
          if (rise) begin mode = MHOLD2; t0 = k; pr = 1'b1; dd = 1'b1; end
          else if (tk && n == DT) begin mode = MIDLE; t0 = k; ck = 1'b1; end
        end
        default: begin
          if (fall) begin mode = MIDLE; t0 = k; rl = 1'b1; end
          else if (tk && n > 0 && (n % RT) == 0) rp = 1'b1;
        end
      endcase
      e_held = (mode == MHOLD) || (mode == MHOLD2) || (mode == MLONG);
      code = dd ? 3'd4 : lg ? 3'd5 : rp ? 3'd6 : ck ? 3'd3 : rl ? 3'd2 : pr ? 3'd1 : 3'd0;
      if (code != 3'd0) begin
        if (!e_valid || bus.evt_ready) begin e_valid = 1'b1; e_code = code; end
        else e_ovr = 1'b1;
      end else if (e_valid && bus.evt_ready) begin
        e_valid = 1'b0;
      end
    end
    exp_vec = {pr, rl, ck, dd, lg, rp, e_held, e_valid, e_code, e_ovr};
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
    obs_vec = {bus.press_p, bus.release_p, bus.click_p, bus.dbl_p, bus.long_p, bus.repeat_p,
               bus.held, bus.evt_valid, 3'(bus.evt_code), bus.overrun};
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.db = 1'b0;
    advance();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.db = 1'b0; bus.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_cmp++;
      if (obs_vec !== 12'd0) begin
        n_bad++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, obs_vec, 12'd0);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_click();
    int clicks = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      bus.db = (c >= 2 && c < 10);
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL click_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
      if (c == 2) begin
        n_cmp++;
        if (bus.press_p !== 1'b1) begin
          n_bad++; $display("FAIL click_press_latency got=%b exp=1", bus.press_p);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (bus.release_p !== 1'b1) begin
          n_bad++; $display("FAIL click_release_latency got=%b exp=1", bus.release_p);
        end
      end
      if (bus.click_p === 1'b1) clicks++;
    end
    n_cmp++;
    if (clicks != 1) begin n_bad++; $display("FAIL click_count got=%0d exp=1", clicks); end
  endtask

  task automatic test_double();
    int dbls = 0, clicks = 0;
    int codes[$];
    do_reset();
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 42; c++) begin
      bus.db = (c < 8) || (c >= 14 && c < 22);
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL double_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
      if (bus.dbl_p === 1'b1) dbls++;
      if (bus.click_p === 1'b1) clicks++;
      if (bus.evt_valid === 1'b1) codes.push_back(int'(bus.evt_code));
    end
    n_cmp++;
    if (dbls != 1 || clicks != 0) begin
      n_bad++; $display("FAIL double_counts dbl=%0d click=%0d exp dbl=1 click=0", dbls, clicks);
    end
    n_cmp++;
    if (codes.size() != 4 || codes[0] != 1 || codes[1] != 2 || codes[2] != 4 || codes[3] != 2) begin
      n_bad++; $display("FAIL double_codes got=%p exp='{1,2,4,2}", codes);
    end
  endtask

  task automatic test_long();
    int longs = 0, reps = 0, rels = 0, clicks = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 56; c++) begin
      bus.db = (c < 40);
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL long_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
      if (c == 40) begin
        n_cmp++;
        if (obs_vec[11:6] !== 6'b010000) begin
          n_bad++; $display("FAIL long_release_only got=%b exp=010000", obs_vec[11:6]);
        end
      end
      longs  += int'(bus.long_p);
      reps   += int'(bus.repeat_p);
      rels   += int'(bus.release_p);
      clicks += int'(bus.click_p);
    end
    n_cmp++;
    if (longs != 1 || reps < 2 || rels != 1 || clicks != 0) begin
      n_bad++;
      $display("FAIL long_counts long=%0d rep=%0d rel=%0d click=%0d exp 1,>=2,1,0",
               longs, reps, rels, clicks);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.evt_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.db = (c >= 1 && c < 5);
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL overrun_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (bus.evt_valid !== 1'b1 || bus.evt_code !== EVT_PRESS || bus.overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_hold got v=%b code=%0d ovr=%b exp v=1 code=1 ovr=1",
                        bus.evt_valid, bus.evt_code, bus.overrun);
    end
    bus.evt_ready = 1'b1;
    advance();
    n_cmp++;
    if (bus.evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL overrun_accept got valid=%b exp=0", bus.evt_valid);
    end
    for (int c = 0; c < 20; c++) begin
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL overrun_tail c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.evt_ready = 1'b0;
    bus.db = 1'b1;
    for (int c = 0; c < 30; c++) begin
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL rstmid_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (bus.held !== 1'b1 || bus.evt_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got held=%b valid=%b exp 1 1", bus.held, bus.evt_valid);
    end
    reset = 1'b0; bus.db = 1'b0;
    advance();
    n_cmp++;
    if (obs_vec !== 12'd0) begin
      n_bad++; $display("FAIL rstmid_reset_cycle got=%b exp=%b", obs_vec, 12'd0);
    end
    reset = 1'b1;
    advance();
    n_cmp++;
    if (obs_vec !== 12'd0) begin
      n_bad++; $display("FAIL rstmid_after got=%b exp=%b", obs_vec, 12'd0);
    end
  endtask

  task automatic test_edge_vs_tick();
    bit found = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    bus.db = 1'b1;
    for (int c = 0; c < 6; c++) advance();
    bus.db = 1'b0;
    advance();
    for (int c = 0; c < 40 && !found; c++) begin
      if (mode == MGAP && tick_at(k + 1) && (nticks(k + 1) - nticks(t0)) == DT) begin
        bus.db = 1'b1;
        found = 1;
      end
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL edgetick_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (!found || bus.dbl_p !== 1'b1 || bus.click_p !== 1'b0) begin
      n_bad++; $display("FAIL edge_beats_tick found=%0d dbl=%b click=%b exp found=1 dbl=1 click=0",
                        found, bus.dbl_p, bus.click_p);
    end
    bus.db = 1'b0;
  endtask

  task automatic test_random();
    int run = 1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      run--;
      if (run <= 0) begin
        bus.db = ~bus.db;
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 14));
      end
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      advance();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL random_trace c=%0d got=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.db = 1'b0;
    bus.evt_ready = 1'b0;
    test_reset();
    test_click();
    test_double();
    test_long();
    test_overrun();
    test_reset_mid();
    test_edge_vs_tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
